// File: rtl/yutorina_bus_slave_responder_pkg.sv
// Shared constants and types for the Yutorina bus slave responder.
package yutorina_bus_slave_responder_pkg;

    // Word address bus width of the Yutorina system bus.
    localparam int unsigned YutorinaWordAddrWidth = 30;

    // rw encodings.
    localparam logic YutorinaBusRead  = 1'b1;
    localparam logic YutorinaBusWrite = 1'b0;

    // Active-low enable/disable polarity used by chip_select_, as_ and rdy_.
    localparam logic YutorinaEnable_  = 1'b0;
    localparam logic YutorinaDisable_ = 1'b1;

    // Wait-state counter width; supports 0..15 wait states.
    localparam int unsigned YutorinaSlaveWaitCntWidth = 4;

    typedef logic [YutorinaWordAddrWidth-1:0]     yutorina_word_addr_t;
    typedef logic [YutorinaSlaveWaitCntWidth-1:0] yutorina_wait_cnt_t;

    typedef enum logic [1:0] {
        YutorinaSlaveIdle    = 2'd0,
        YutorinaSlaveWait    = 2'd1,
        YutorinaSlaveRespond = 2'd2
    } yutorina_slave_state_e;

    // Counter value loaded at accept: the count reaches zero on the last wait cycle.
    function automatic yutorina_wait_cnt_t wait_load(input int unsigned wait_cycles);
        int unsigned w;
        if (wait_cycles == 0) begin
            return '0;
        end
        w = wait_cycles - 1;
        return w[YutorinaSlaveWaitCntWidth-1:0];
    endfunction

endpackage

// File: rtl/yutorina_bus_slave_responder_if.sv
// Slave-side view of the Yutorina bus: strobe, select, address, data and ready.
interface yutorina_bus_slave_responder_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    import yutorina_bus_slave_responder_pkg::*;

    logic                  chip_select_;
    logic                  as_;
    logic                  rw;
    yutorina_word_addr_t   slave_address;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rdy_;

    modport master (
        output chip_select_,
        output as_,
        output rw,
        output slave_address,
        output wr_data,
        input  rd_data,
        input  rdy_
    );

    modport slave (
        input  chip_select_,
        input  as_,
        input  rw,
        input  slave_address,
        input  wr_data,
        output rd_data,
        output rdy_
    );

endinterface

// File: rtl/yutorina_bus_slave_responder_regfile.sv
// Local register bank for the slave responder. The all-ones index is a read-only
// count of completed accesses. Writes and the read port both act on the commit edge.
module yutorina_bus_slave_responder_regfile #(
    parameter int unsigned REG_ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                      clk,
    input  logic                      reset_,
    input  logic                      commit_i,
    input  logic                      rw_i,
    input  logic [REG_ADDR_WIDTH-1:0] index_i,
    input  logic [DATA_WIDTH-1:0]     wr_data_i,
    output logic [DATA_WIDTH-1:0]     rd_data_o
);
    import yutorina_bus_slave_responder_pkg::*;

    localparam int unsigned RegCount = 1 << REG_ADDR_WIDTH;
    localparam logic [REG_ADDR_WIDTH-1:0] CntIndex = '1;

    logic [DATA_WIDTH-1:0] regs_q [RegCount];
    logic [DATA_WIDTH-1:0] access_cnt_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic                  is_cnt;

    assign is_cnt = (index_i == CntIndex);

    // Register writes, access counting and the registered read port.
    // rd_data_q holds a value only in the cycle after a read commit, so it is zero
    // whenever no response is being driven.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            for (int i = 0; i < int'(RegCount); i++) begin
                regs_q[i] <= '0;
            end
            access_cnt_q <= '0;
            rd_data_q    <= '0;
        end else begin
            rd_data_q <= '0;
            if (commit_i) begin
                // Counter wraps naturally; a read of it sees the pre-increment value.
                access_cnt_q <= access_cnt_q + 1'b1;
                if (rw_i == YutorinaBusRead) begin
                    rd_data_q <= is_cnt ? access_cnt_q : regs_q[index_i];
                end else if (!is_cnt) begin
                    regs_q[index_i] <= wr_data_i;
                end
            end
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/yutorina_bus_slave_responder.sv
// Generic Yutorina bus slave endpoint: accepts a strobe, waits WAIT_CYCLES, then
// answers with a one-cycle active-low ready and (for reads) the register contents.
module yutorina_bus_slave_responder #(
    parameter int unsigned WAIT_CYCLES    = 2,
    parameter int unsigned REG_ADDR_WIDTH = 3,
    parameter int unsigned DATA_WIDTH     = 32
) (
    input  logic                            clk,
    input  logic                            reset_,
    yutorina_bus_slave_responder_if.slave   bus
);
    import yutorina_bus_slave_responder_pkg::*;

    localparam yutorina_wait_cnt_t WaitLoad = wait_load(WAIT_CYCLES);

    yutorina_slave_state_e     state_q;
    yutorina_wait_cnt_t        wait_cnt_q;
    logic                      rdy_q;
    logic [REG_ADDR_WIDTH-1:0] index_q;
    logic                      rw_q;
    logic [DATA_WIDTH-1:0]     wr_data_q;

    logic                      accept;
    logic                      commit_direct;
    logic                      commit_from_wait;
    logic                      commit;
    logic                      commit_rw;
    logic [REG_ADDR_WIDTH-1:0] commit_index;
    logic [DATA_WIDTH-1:0]     commit_wr_data;
    logic [DATA_WIDTH-1:0]     rf_rd_data;

    // Upper address bits alias onto the register index and are intentionally dropped.
    logic unused_addr;
    assign unused_addr = ^bus.slave_address[YutorinaWordAddrWidth-1:REG_ADDR_WIDTH];

    // Accept decode and selection of the access being committed this edge.
    // With zero wait states the commit happens on the accept edge itself, so the
    // live bus fields are used instead of the latched copies.
    always_comb begin
        accept           = 1'b0;
        commit_direct    = 1'b0;
        commit_from_wait = 1'b0;
        commit           = 1'b0;
        commit_rw        = rw_q;
        commit_index     = index_q;
        commit_wr_data   = wr_data_q;

        accept = (bus.chip_select_ == YutorinaEnable_) && (bus.as_ == YutorinaEnable_) &&
                 ((state_q == YutorinaSlaveIdle) || (state_q == YutorinaSlaveRespond));
        commit_direct    = accept && (WAIT_CYCLES == 0);
        commit_from_wait = (state_q == YutorinaSlaveWait) && (wait_cnt_q == '0);
        commit           = commit_direct || commit_from_wait;

        if (commit_direct) begin
            commit_rw      = bus.rw;
            commit_index   = bus.slave_address[REG_ADDR_WIDTH-1:0];
            commit_wr_data = bus.wr_data;
        end
    end

    // Access FSM with registered ready; a reset mid-access drops it without a response.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q    <= YutorinaSlaveIdle;
            wait_cnt_q <= '0;
            rdy_q      <= YutorinaDisable_;
            index_q    <= '0;
            rw_q       <= YutorinaBusWrite;
            wr_data_q  <= '0;
        end else begin
            rdy_q <= YutorinaDisable_;
            unique case (state_q)
                YutorinaSlaveIdle, YutorinaSlaveRespond: begin
                    if (accept) begin
                        index_q   <= bus.slave_address[REG_ADDR_WIDTH-1:0];
                        rw_q      <= bus.rw;
                        wr_data_q <= bus.wr_data;
                        if (WAIT_CYCLES == 0) begin
                            state_q <= YutorinaSlaveRespond;
                            rdy_q   <= YutorinaEnable_;
                        end else begin
                            state_q    <= YutorinaSlaveWait;
                            wait_cnt_q <= WaitLoad;
                        end
                    end else begin
                        state_q <= YutorinaSlaveIdle;
                    end
                end
                // Strobes seen here are protocol violations and are ignored.
                YutorinaSlaveWait: begin
                    if (wait_cnt_q == '0) begin
                        state_q <= YutorinaSlaveRespond;
                        rdy_q   <= YutorinaEnable_;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= YutorinaSlaveIdle;
                end
            endcase
        end
    end

    yutorina_bus_slave_responder_regfile #(
        .REG_ADDR_WIDTH (REG_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH)
    ) u_regfile (
        .clk        (clk),
        .reset_     (reset_),
        .commit_i   (commit),
        .rw_i       (commit_rw),
        .index_i    (commit_index),
        .wr_data_i  (commit_wr_data),
        .rd_data_o  (rf_rd_data)
    );

    // Gate read data with ready so the output can be OR-muxed with other slaves.
    assign bus.rdy_    = rdy_q;
    assign bus.rd_data = (rdy_q == YutorinaEnable_) ? rf_rd_data : '0;

endmodule

// File: tb/tb_yutorina_bus_slave_responder.sv
// Bench for the slave responder: one instance with two wait states, one with none.
module tb_yutorina_bus_slave_responder;

    typedef struct {
        bit          is0;
        bit          rw;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_ = 1'b0;
    logic        cs2_ = 1'b1;
    logic        cs0_ = 1'b1;
    logic        as_ = 1'b1;
    logic        rw = 1'b0;
    logic [29:0] addr = '0;
    logic [31:0] wdata = '0;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t q2[$];
    exp_t q0[$];
    vec_t vecs[13];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    yutorina_bus_slave_responder_if #(.DATA_WIDTH(32)) bus2 ();
    yutorina_bus_slave_responder_if #(.DATA_WIDTH(32)) bus0 ();

    assign bus2.chip_select_  = cs2_;
    assign bus2.as_           = as_;
    assign bus2.rw            = rw;
    assign bus2.slave_address = addr;
    assign bus2.wr_data       = wdata;
    assign bus0.chip_select_  = cs0_;
    assign bus0.as_           = as_;
    assign bus0.rw            = rw;
    assign bus0.slave_address = addr;
    assign bus0.wr_data       = wdata;

    yutorina_bus_slave_responder #(
        .WAIT_CYCLES    (2),
        .REG_ADDR_WIDTH (3),
        .DATA_WIDTH     (32)
    ) dut2 (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus2)
    );

    yutorina_bus_slave_responder #(
        .WAIT_CYCLES    (0),
        .REG_ADDR_WIDTH (3),
        .DATA_WIDTH     (32)
    ) dut0 (
        .clk    (clk),
        .reset_ (reset_),
        .bus    (bus0)
    );

    // Scoreboard check of one DUT's outputs for the current cycle.
    task automatic check_one(input string nm, input logic rdy, input logic [31:0] rd,
                             input bit is0);
        exp_t e;
        bit   have;
        if (rdy === 1'b0) begin
            have = is0 ? (q0.size() != 0) : (q2.size() != 0);
            checks++;
            if (!have) begin
                errors++;
                $display("FAIL %s unexpected_rdy: got rdy_=0 at cycle %0d, required rdy_=1",
                         nm, cyc);
            end else begin
                e = is0 ? q0.pop_front() : q2.pop_front();
                checks++;
                if (rd !== e.data) begin
                    errors++;
                    $display("FAIL %s rd_data: got %h, required %h (cycle %0d)",
                             nm, rd, e.data, cyc);
                end
                checks++;
                if (cyc != e.cyc) begin
                    errors++;
                    $display("FAIL %s latency: rdy_ at cycle %0d, required cycle %0d",
                             nm, cyc, e.cyc);
                end
            end
        end else begin
            checks++;
            if (rdy !== 1'b1 || rd !== 32'h0) begin
                errors++;
                $display("FAIL %s idle: got rdy_=%b rd_data=%h, required rdy_=1 rd_data=0",
                         nm, rdy, rd);
            end
        end
    endtask

    // Advance to the next falling edge and check both DUTs there.
    task automatic tick();
        @(negedge clk);
        check_one("w2", bus2.rdy_, bus2.rd_data, 1'b0);
        check_one("w0", bus0.rdy_, bus0.rd_data, 1'b1);
    endtask

    // Drive one strobe and record its expected response.
    task automatic issue(input bit is0, input bit r, input logic [29:0] a,
                         input logic [31:0] d, input logic [31:0] exp);
        exp_t e;
        cs0_  = is0 ? 1'b0 : 1'b1;
        cs2_  = is0 ? 1'b1 : 1'b0;
        as_   = 1'b0;
        rw    = r;
        addr  = a;
        wdata = d;
        e.data = exp;
        e.cyc  = cyc + 1 + (is0 ? 0 : 2);
        if (is0) q0.push_back(e);
        else q2.push_back(e);
    endtask

    task automatic idle();
        cs0_ = 1'b1;
        cs2_ = 1'b1;
        as_  = 1'b1;
    endtask

    // Wait for all outstanding responses, bounded.
    task automatic drain();
        for (int k = 0; k < 40 && (q2.size() != 0 || q0.size() != 0); k++) begin
            tick();
        end
        checks++;
        if (q2.size() != 0 || q0.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d/%0d pending, required 0/0",
                     q2.size(), q0.size());
            q2.delete();
            q0.delete();
        end
    endtask

    initial begin
        bit got;

        //           is0  rw    addr            wdata          expected
        vecs[0]  = '{1'b0, 1'b1, 30'h0,         32'h0,         32'h0};
        vecs[1]  = '{1'b0, 1'b0, 30'h1,         32'hDEADBEEF,  32'h0};
        vecs[2]  = '{1'b0, 1'b1, 30'h1,         32'h0,         32'hDEADBEEF};
        vecs[3]  = '{1'b0, 1'b1, 30'h9,         32'h0,         32'hDEADBEEF};
        vecs[4]  = '{1'b0, 1'b0, 30'h3,         32'h0BADF00D,  32'h0};
        vecs[5]  = '{1'b0, 1'b1, 30'h7,         32'h0,         32'd5};
        vecs[6]  = '{1'b0, 1'b0, 30'h7,         32'h0000FFFF,  32'h0};
        vecs[7]  = '{1'b0, 1'b1, 30'h7,         32'h0,         32'd7};
        vecs[8]  = '{1'b0, 1'b1, 30'h3FFFFFFB,  32'h0,         32'h0BADF00D};
        vecs[9]  = '{1'b1, 1'b0, 30'h4,         32'hCAFEF00D,  32'h0};
        vecs[10] = '{1'b1, 1'b1, 30'h2C,        32'h0,         32'hCAFEF00D};
        vecs[11] = '{1'b1, 1'b1, 30'hF,         32'h0,         32'd2};
        vecs[12] = '{1'b1, 1'b1, 30'h1,         32'h0,         32'h0};

        // Power-on reset.
        idle();
        reset_ = 1'b0;
        repeat (3) tick();
        reset_ = 1'b1;
        tick();

        // Populate index 0, then abort an in-flight write with reset.
        issue(1'b0, 1'b0, 30'h0, 32'hA5A5A5A5, 32'h0);
        tick();
        idle();
        drain();
        issue(1'b0, 1'b1, 30'h0, 32'h0, 32'hA5A5A5A5);
        tick();
        idle();
        drain();
        issue(1'b0, 1'b0, 30'h0, 32'h11111111, 32'h0);
        tick();
        idle();
        reset_ = 1'b0;
        q2.delete();
        repeat (3) tick();
        reset_ = 1'b1;
        repeat (5) tick();

        // Table of single accesses (registers and counters start from reset).
        for (int i = 0; i < 13; i++) begin
            issue(vecs[i].is0, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
            tick();
            idle();
            drain();
        end

        // Back-to-back with wait states: read accepted in the write's RESPOND cycle.
        issue(1'b0, 1'b0, 30'h2, 32'h12345678, 32'h0);
        tick();
        idle();
        got = 1'b0;
        for (int k = 0; k < 10 && !got; k++) begin
            tick();
            if (bus2.rdy_ === 1'b0) got = 1'b1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL b2b_rdy_timeout: got no rdy_, required rdy_=0 within 10 cycles");
        end
        issue(1'b0, 1'b1, 30'h2, 32'h0, 32'h12345678);
        tick();
        idle();
        drain();

        // Strobes during WAIT are ignored: one response, register and count unchanged.
        issue(1'b0, 1'b1, 30'h2, 32'h0, 32'h12345678);
        tick();
        cs2_  = 1'b0;
        as_   = 1'b0;
        rw    = 1'b0;
        addr  = 30'h2;
        wdata = 32'h0;
        repeat (2) tick();
        idle();
        drain();
        issue(1'b0, 1'b1, 30'h2, 32'h0, 32'h12345678);
        tick();
        idle();
        drain();
        issue(1'b0, 1'b1, 30'h7, 32'h0, 32'd13);
        tick();
        idle();
        drain();

        // Strobe with both chip selects deasserted for 10 cycles has no effect.
        cs2_  = 1'b1;
        cs0_  = 1'b1;
        as_   = 1'b0;
        rw    = 1'b0;
        addr  = 30'h1;
        wdata = 32'hFFFFFFFF;
        repeat (10) tick();
        idle();
        issue(1'b0, 1'b1, 30'h1, 32'h0, 32'hDEADBEEF);
        tick();
        idle();
        drain();
        issue(1'b0, 1'b1, 30'h7, 32'h0, 32'd15);
        tick();
        idle();
        drain();

        // Zero wait states, strobe held low: write, read-back, counter read in a row.
        issue(1'b1, 1'b0, 30'h5, 32'h0F0F0F0F, 32'h0);
        tick();
        issue(1'b1, 1'b1, 30'h5, 32'h0, 32'h0F0F0F0F);
        tick();
        issue(1'b1, 1'b1, 30'h7, 32'h0, 32'd6);
        tick();
        idle();
        drain();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
